// File: rtl/seg_pkg.sv
// Shared definitions for the 4-digit display scan multiplexer.
//   SEG_DIGITS - number of digits on the display
//   SEL_W      - width of the digit-select counter
//   AN_OFF     - all anodes disabled (active-low pins)
//   onehot_an  - active-low anode pattern that enables only digit `sel`
package seg_pkg;

  localparam int         SEG_DIGITS = 4;
  localparam int         SEL_W      = 2;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  function automatic logic [SEG_DIGITS-1:0] onehot_an(input logic [SEL_W-1:0] sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Digit-advance strobe generator.
//   clk     in  system clock
//   reset   in  synchronous, active-high reset
//   tick    out high for the one cycle in which div_cnt == DIV-1
// Parameters CLK_HZ / SCAN_HZ set DIV = CLK_HZ/SCAN_HZ (must be >= 2).
module scan_tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] div_cnt;

  // Decoded straight off the counter register, so the strobe is glitch-free
  // and lasts exactly one cycle per DIV.
  assign tick = (div_cnt == CNT_W'(DIV - 1));

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes four BCD digits onto the shared segment bus of a
// 4-digit display. The digit word is snapshotted once per frame so a time
// update never tears mid-scan.
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   digits      in   {d3,d2,d1,d0}, d0 = rightmost
//   dp_mask     in   1 = light decimal point of that digit (sampled live)
//   blank_mask  in   1 = force digit dark (sampled live)
//   blink_mask  in   1 = digit blinks (only with SEG_BLINK_EN)
//   digit_out   out  nibble for the downstream seven-segment decoder
//   an          out  anode enables, active-low, one-hot or all-high
//   dp          out  decimal point, active-low
//   frame_start out  one-cycle pulse when the scan wraps to digit 0
// Build option: define SEG_BLINK_EN to enable the blink phase counter.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*SEG_DIGITS-1:0]   digits,
  input  logic [SEG_DIGITS-1:0]     dp_mask,
  input  logic [SEG_DIGITS-1:0]     blank_mask,
  input  logic [SEG_DIGITS-1:0]     blink_mask,
  output logic [3:0]                digit_out,
  output logic [SEG_DIGITS-1:0]     an,
  output logic                      dp,
  output logic                      frame_start
);

  logic                    tick;
  logic                    tick_d;
  logic [SEL_W-1:0]        sel;
  logic [SEL_W-1:0]        next_sel;
  logic [4*SEG_DIGITS-1:0] snapshot;
  logic                    blink_dark;
  logic                    dark;

  scan_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .SCAN_HZ (SCAN_HZ)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-bit select wraps 3 -> 0 naturally.
  assign next_sel = sel + SEL_W'(1);

`ifdef SEG_BLINK_EN
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BC_W-1:0] blink_cnt;
  logic            blink_phase;

  // Counted on the same edge that raises frame_start, so the new phase is
  // already valid when digit 0's anode decision is made one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick && (next_sel == '0)) begin
      if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BC_W'(1);
      end
    end
  end

  assign blink_dark = blink_phase & blink_mask[sel];
`else
  logic unused_blink;
  assign unused_blink = (^blink_mask) ^ BLINK_FRAMES[0];
  assign blink_dark   = 1'b0;
`endif

  assign dark = blank_mask[sel] | blink_dark;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_d      <= 1'b0;
      sel         <= '0;
      snapshot    <= '0;
      an          <= AN_OFF;
      digit_out   <= 4'h0;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      tick_d      <= tick;
      frame_start <= 1'b0;
      if (tick) begin
        // Anodes go dark for one cycle while the segment data changes, so
        // the previous digit's pattern never ghosts onto the next one.
        sel <= next_sel;
        an  <= AN_OFF;
        dp  <= ~dp_mask[next_sel];
        if (next_sel == '0) begin
          snapshot    <= digits;
          digit_out   <= digits[3:0];
          frame_start <= 1'b1;
        end else begin
          digit_out <= snapshot[{next_sel, 2'b00} +: 4];
        end
      end else if (tick_d) begin
        an <= dark ? AN_OFF : onehot_an(sel);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux (DIV = 4, BLINK_FRAMES = 2).
// The reference model works from the cycle count since reset release:
// every DIV-th edge starts a new slot, slot k shows digit k mod 4, and the
// anode lights one edge after the slot starts.
module tb_seg_scan_mux;

  localparam int DIV = 4;
  localparam int BF  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp_mask, blank_mask, blink_mask;
  logic [3:0]  digit_out;
  logic [3:0]  an;
  logic        dp;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          n;
  int          m_sel;
  int          m_frames;
  logic [15:0] m_snap;
  logic [3:0]  m_an, m_digit;
  logic        m_dp, m_fs;
  int          fs_seen;

  seg_scan_mux #(
    .CLK_HZ       (8),
    .SCAN_HZ      (2),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits      (digits),
    .dp_mask     (dp_mask),
    .blank_mask  (blank_mask),
    .blink_mask  (blink_mask),
    .digit_out   (digit_out),
    .an          (an),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    int   s;
    logic dark;
    if (reset) begin
      n = 0; m_sel = 0; m_frames = 0; m_snap = 16'h0000;
      m_an = 4'b1111; m_digit = 4'h0; m_dp = 1'b1; m_fs = 1'b0;
    end else begin
      n++;
      m_fs = 1'b0;
      if (n % DIV == 0) begin
        s = (n / DIV) % 4;
        m_sel = s;
        m_an  = 4'b1111;
        if (s == 0) begin
          m_snap = digits;
          m_fs   = 1'b1;
          m_frames++;
        end
        m_digit = m_snap[s*4 +: 4];
        m_dp    = ~dp_mask[s];
      end else if (n % DIV == 1 && n > 1) begin
        s    = m_sel;
        dark = blank_mask[s];
`ifdef SEG_BLINK_EN
        if (((m_frames / BF) % 2 == 1) && blink_mask[s]) dark = 1'b1;
`endif
        m_an = dark ? 4'b1111 : ~(4'b0001 << s);
      end
    end
  endtask

  task automatic compare();
    checks++;
    assert (an === m_an) else begin
      errors++; $error("FAIL an: got %b expected %b (n=%0d)", an, m_an, n);
    end
    checks++;
    assert (digit_out === m_digit) else begin
      errors++; $error("FAIL digit_out: got %h expected %h (n=%0d)", digit_out, m_digit, n);
    end
    checks++;
    assert (dp === m_dp) else begin
      errors++; $error("FAIL dp: got %b expected %b (n=%0d)", dp, m_dp, n);
    end
    checks++;
    assert (frame_start === m_fs) else begin
      errors++; $error("FAIL frame_start: got %b expected %b (n=%0d)", frame_start, m_fs, n);
    end
    checks++;
    assert ($countones(~an) <= 1) else begin
      errors++; $error("FAIL an_onehot: got %b expected at most one low", an);
    end
  endtask

  task automatic step(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      if (frame_start) fs_seen++;
      compare();
    end
  endtask

  // Bounded wait until the scan has just entered slot `s`.
  task automatic wait_slot(input int s);
    int guard;
    guard = 0;
    while (!(m_sel == s && n % DIV == 0) && guard < 64) begin
      step(1);
      guard++;
    end
    checks++;
    assert (guard < 64) else begin
      errors++; $error("FAIL wait_slot: got timeout expected slot %0d", s);
    end
  endtask

  initial begin
    reset = 1'b1; digits = 16'h0000;
    dp_mask = 4'h0; blank_mask = 4'h0; blink_mask = 4'h0;
    fs_seen = 0;

    // Reset held three cycles, then released; dark until the first tick.
    step(3);
    reset = 1'b0;
    step(3);
    checks++;
    assert (an === 4'b1111 && digit_out === 4'h0 && dp === 1'b1) else begin
      errors++; $error("FAIL pre_tick: got an=%b digit=%h dp=%b expected 1111/0/1", an, digit_out, dp);
    end

    // Basic scan: 1234 across three frames.
    digits = 16'h1234;
    step(3 * 4 * DIV);

    // Mid-frame digit change must not tear the current frame.
    wait_slot(2);
    digits = 16'h5678;
    checks++;
    assert (digit_out === 4'h2) else begin
      errors++; $error("FAIL no_tear: got %h expected 2", digit_out);
    end
    step(2 * 4 * DIV);

    // Blank d3, decimal point on d2.
    blank_mask = 4'b1000;
    dp_mask    = 4'b0100;
    step(2 * 4 * DIV);

    // Blink on d0/d1 (only effective with SEG_BLINK_EN).
    blank_mask = 4'b0000;
    dp_mask    = 4'b0000;
    blink_mask = 4'b0011;
    step(8 * 4 * DIV);
    blink_mask = 4'b0000;

    // Reset during the d2 slot, then count frame_start pulses.
    wait_slot(2);
    step(1);
    reset = 1'b1;
    step(1);
    checks++;
    assert (an === 4'b1111 && digit_out === 4'h0 && frame_start === 1'b0) else begin
      errors++; $error("FAIL mid_reset: got an=%b digit=%h fs=%b expected 1111/0/0", an, digit_out, frame_start);
    end
    reset = 1'b0;
    fs_seen = 0;
    step(64);
    checks++;
    assert (fs_seen == 4) else begin
      errors++; $error("FAIL fs_rate: got %0d expected 4", fs_seen);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) digits     = 16'($urandom);
      if ($urandom_range(0, 15) == 0) dp_mask    = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      step(1);
    end
    reset = 1'b0;
    step(2 * 4 * DIV);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
